opcode_decoder: RTL and testbench
=================================

OPCODE_DECODER -- requirements
Module: opcode_decoder

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: ir_load  input  1  capture instr_in into instruction register this edge.
REQ-004 SHALL have port: flush  input  1  replace held instruction with NOOP this edge.
REQ-005 SHALL have port: instr_in  input  16  instruction word from code memory: [15:12] opcode, [11:10] RX, [9:8] RY, [7:0] immediate.
REQ-006 SHALL have port: opcode_out  output  27  registered decode: [22:0] one-hot class, [26:25] RX, [24:23] RY.
REQ-007 SHALL have port: imm_out  output  8  registered instr[7:0].
REQ-008 SHALL have port: ir_valid  output  1  high once a non-flushed instruction is held.
REQ-009 SHALL have port: illegal  output  1  sticky illegal-encoding flag (see Configuration).
REQ-010 SHALL have port: instr_count  output  16  count of ir_load captures.

Function
REQ-011 SHALL decode opcode_out[22:0] to exactly one hot bit: bit0 NOOP(0000); bits1-4 INPUTC/INPUTCF/INPUTD/INPUTDF (0001, RY=00/01/10/11); bit5 MOVE(0010); bit6 LOADI/LOADP(0011); bit7 ADD(0100); bit8 ADDI(0101); bit9 SUB(0110); bit10 SUBI(0111); bit11 LOAD(1000); bit12 LOADF(1001); bit13 STORE(1010); bit14 STOREF(1011); bits15/16 SHIFTL/SHIFTR (1100, instr[8]=0/1); bit17 CMP(1101); bit18 JUMP(1110); bits19-22 BRE/BRNE/BRG/BRGE (1111, RX=00/01/10/11).
REQ-012 SHALL register all outputs; latency from ir_load edge to decoded outputs = 0 cycles after that edge (valid for the entire following cycle).
REQ-013 SHALL hold opcode_out, imm_out, ir_valid unchanged while ir_load=0 and flush=0.
REQ-014 SHALL, on flush=1, load opcode_out=27'h1 (NOOP, RX=RY=0), imm_out=0, ir_valid=0.
REQ-015 SHALL give flush priority over ir_load on the same edge; instr_count still increments for that ir_load.
REQ-016 SHALL increment instr_count by 1 per edge with ir_load=1, modulo 2^16 (0xFFFF -> 0x0000).
REQ-017 SHALL set ir_valid=1 on any edge with ir_load=1 and flush=0.
REQ-018 SHALL keep opcode_out[22:0] one-hot at all times, including after reset and flush.

Reset
REQ-019 SHALL, on reset=1 at an edge, set opcode_out=27'h1, imm_out=0, ir_valid=0, illegal=0, instr_count=0.
REQ-020 SHALL give reset priority over flush and ir_load, including mid-stream.

Configuration
REQ-021 SHALL, with macro OPCODE_ILLEGAL_TRAP_EN defined, treat JUMP with instr[11:8]!=0000 and SHIFT with instr[9]!=0 as illegal: decode as NOOP (opcode_out=27'h1), set illegal=1 sticky until reset.
REQ-022 SHALL, without OPCODE_ILLEGAL_TRAP_EN, decode those encodings per REQ-011 ignoring reserved bits, and tie illegal to 0.

Verification
REQ-023 Reset then ir_load=1, instr_in=16'h4600 -> next cycle opcode_out[7]=1, RX=01, RY=10, imm_out=0x00, ir_valid=1, instr_count=1.
REQ-024 ir_load=1 with instr_in=16'hF9FE -> opcode_out[21]=1 (BRG), RX=10, RY=01, imm_out=0xFE; hold ir_load=0 three cycles -> outputs unchanged.
REQ-025 ir_load=1 and flush=1 same edge, instr_in=16'h5123 -> opcode_out=27'h1, ir_valid=0, instr_count incremented.
REQ-026 Preload instr_count=0xFFFF via 65535 loads, one more load -> instr_count=0x0000.
REQ-027 With OPCODE_ILLEGAL_TRAP_EN: load 16'hE100 -> opcode_out=27'h1, illegal=1; load 16'h4000 -> ADD decoded, illegal stays 1; reset -> illegal=0. Without macro: 16'hE100 -> opcode_out[18]=1, illegal=0.
REQ-028 Sweep all 16 opcodes x RX/RY -> exactly one bit of opcode_out[22:0] set, matching REQ-011.

Source files
------------

// File: rtl/opcode_decoder.sv
// opcode_decoder
//   Instruction register plus registered one-hot decode of a 16-bit
//   instruction word ([15:12] opcode, [11:10] RX, [9:8] RY, [7:0] imm).
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high; wins over flush and ir_load
//   ir_load      in   capture instr_in this edge
//   flush        in   replace held instruction with NOOP; wins over ir_load
//   instr_in     in   [15:0] instruction word
//   opcode_out   out  [26:0] {RX, RY, 23-bit one-hot class}
//   imm_out      out  [7:0] held immediate
//   ir_valid     out  a non-flushed instruction is held
//   illegal      out  sticky illegal-encoding flag (0 unless trap enabled)
//   instr_count  out  [15:0] number of ir_load edges, wraps at 2^16
//
// Optional feature: define OPCODE_ILLEGAL_TRAP_EN to trap JUMP with
// non-zero instr[11:8] and SHIFT with instr[9]=1 as illegal (decoded as
// NOOP, illegal flag set until reset).
module opcode_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        ir_load,
  input  logic        flush,
  input  logic [15:0] instr_in,
  output logic [26:0] opcode_out,
  output logic [7:0]  imm_out,
  output logic        ir_valid,
  output logic        illegal,
  output logic [15:0] instr_count
);

  localparam logic [26:0] NOOP_WORD = 27'h1;

  logic [26:0] opcode_q, opcode_d;
  logic [7:0]  imm_q, imm_d;
  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;
  logic [15:0] count_q, count_d;

  logic [3:0]  op;
  logic [1:0]  rx;
  logic [1:0]  ry;
  logic [4:0]  class_idx;
  logic [22:0] dec_class;
  logic        dec_illegal;

  assign op = instr_in[15:12];
  assign rx = instr_in[11:10];
  assign ry = instr_in[9:8];

  // Map the opcode (plus sub-select field) to a single class index, then
  // expand to one-hot so the class vector can never carry two bits.
  always_comb begin
    class_idx   = 5'd0;
    dec_illegal = 1'b0;
    case (op)
      4'h0: class_idx = 5'd0;
      4'h1: class_idx = 5'd1 + {3'b000, ry};
      4'h2: class_idx = 5'd5;
      4'h3: class_idx = 5'd6;
      4'h4: class_idx = 5'd7;
      4'h5: class_idx = 5'd8;
      4'h6: class_idx = 5'd9;
      4'h7: class_idx = 5'd10;
      4'h8: class_idx = 5'd11;
      4'h9: class_idx = 5'd12;
      4'hA: class_idx = 5'd13;
      4'hB: class_idx = 5'd14;
      4'hC: begin
        class_idx = 5'd15 + {4'b0000, instr_in[8]};
`ifdef OPCODE_ILLEGAL_TRAP_EN
        dec_illegal = instr_in[9];
`endif
      end
      4'hD: class_idx = 5'd17;
      4'hE: begin
        class_idx = 5'd18;
`ifdef OPCODE_ILLEGAL_TRAP_EN
        dec_illegal = (instr_in[11:8] != 4'b0000);
`endif
      end
      4'hF: class_idx = 5'd19 + {3'b000, rx};
      default: class_idx = 5'd0;
    endcase
    dec_class = 23'd1 << class_idx;
  end

  always_comb begin
    opcode_d  = opcode_q;
    imm_d     = imm_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    count_d   = count_q + {15'd0, ir_load};
    if (flush) begin
      opcode_d = NOOP_WORD;
      imm_d    = '0;
      valid_d  = 1'b0;
    end else if (ir_load) begin
      opcode_d  = dec_illegal ? NOOP_WORD : {rx, ry, dec_class};
      imm_d     = instr_in[7:0];
      valid_d   = 1'b1;
      illegal_d = illegal_q | dec_illegal;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opcode_q  <= NOOP_WORD;
      imm_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      opcode_q  <= opcode_d;
      imm_q     <= imm_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign opcode_out  = opcode_q;
  assign imm_out     = imm_q;
  assign ir_valid    = valid_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_opcode_decoder.sv
// Directed self-checking bench for opcode_decoder.
module tb_opcode_decoder;

  logic        clock;
  logic        reset;
  logic        ir_load;
  logic        flush;
  logic [15:0] instr_in;
  logic [26:0] opcode_out;
  logic [7:0]  imm_out;
  logic        ir_valid;
  logic        illegal;
  logic [15:0] instr_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  opcode_decoder dut (
    .clock       (clock),
    .reset       (reset),
    .ir_load     (ir_load),
    .flush       (flush),
    .instr_in    (instr_in),
    .opcode_out  (opcode_out),
    .imm_out     (imm_out),
    .ir_valid    (ir_valid),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic rst, input logic ld, input logic fl, input logic [15:0] ins);
    reset    = rst;
    ir_load  = ld;
    flush    = fl;
    instr_in = ins;
    @(posedge clock);
    #1;
  endtask

  // Expected 27-bit decode for an instruction, built from a class table.
  function automatic logic [26:0] expect_decode(input logic [15:0] ins);
    int unsigned base [16] = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};
    int unsigned op;
    int unsigned bitpos;
    logic [22:0] cls;
    op = int'(ins[15:12]);
    bitpos = base[op];
    if (op == 1)  bitpos = bitpos + int'(ins[9:8]);
    if (op == 12) bitpos = bitpos + int'(ins[8]);
    if (op == 15) bitpos = bitpos + int'(ins[11:10]);
`ifdef OPCODE_ILLEGAL_TRAP_EN
    if (op == 12 && ins[9]) return 27'h1;
    if (op == 14 && ins[11:8] != 4'h0) return 27'h1;
`endif
    cls = '0;
    cls[bitpos] = 1'b1;
    return {ins[11:10], ins[9:8], cls};
  endfunction

  logic [15:0] word;
  logic [26:0] exp_op;
  logic [15:0] exp_cnt;

  initial begin
    reset = 1'b1; ir_load = 1'b0; flush = 1'b0; instr_in = '0;
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("rst_opcode", 32'(opcode_out), 32'h1);
    check("rst_imm", 32'(imm_out), 32'h0);
    check("rst_valid", 32'(ir_valid), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_count", 32'(instr_count), 32'h0);

    // ADD RX=01 RY=10
    step(1'b0, 1'b1, 1'b0, 16'h4600);
    check("add_opcode", 32'(opcode_out), 32'h0300_0080);
    check("add_imm", 32'(imm_out), 32'h00);
    check("add_valid", 32'(ir_valid), 32'h1);
    check("add_count", 32'(instr_count), 32'h1);

    // BRG RX=10 RY=01 imm FE, then hold three cycles
    step(1'b0, 1'b1, 1'b0, 16'hF9FE);
    check("brg_opcode", 32'(opcode_out), 32'h04A0_0000);
    check("brg_imm", 32'(imm_out), 32'hFE);
    check("brg_count", 32'(instr_count), 32'h2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h1234);
      check("hold_opcode", 32'(opcode_out), 32'h04A0_0000);
      check("hold_imm", 32'(imm_out), 32'hFE);
      check("hold_valid", 32'(ir_valid), 32'h1);
      check("hold_count", 32'(instr_count), 32'h2);
    end

    // flush and load on the same edge
    step(1'b0, 1'b1, 1'b1, 16'h5123);
    check("fl_opcode", 32'(opcode_out), 32'h1);
    check("fl_imm", 32'(imm_out), 32'h0);
    check("fl_valid", 32'(ir_valid), 32'h0);
    check("fl_count", 32'(instr_count), 32'h3);

    // flush alone does not count
    step(1'b0, 1'b1, 1'b0, 16'h2A55);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    check("fl2_opcode", 32'(opcode_out), 32'h1);
    check("fl2_count", 32'(instr_count), 32'h4);

    // JUMP with reserved bits set
    step(1'b0, 1'b1, 1'b0, 16'hE100);
`ifdef OPCODE_ILLEGAL_TRAP_EN
    check("jmp_opcode", 32'(opcode_out), 32'h1);
    check("jmp_illegal", 32'(illegal), 32'h1);
    step(1'b0, 1'b1, 1'b0, 16'h4000);
    check("add2_opcode", 32'(opcode_out), 32'h80);
    check("add2_illegal", 32'(illegal), 32'h1);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("ill_reset", 32'(illegal), 32'h0);
`else
    check("jmp_opcode", 32'(opcode_out), 32'h0084_0000);
    check("jmp_illegal", 32'(illegal), 32'h0);
`endif

    // reset wins over load and flush mid-stream
    step(1'b0, 1'b1, 1'b0, 16'h3C77);
    step(1'b1, 1'b1, 1'b1, 16'h4600);
    check("rp_opcode", 32'(opcode_out), 32'h1);
    check("rp_imm", 32'(imm_out), 32'h0);
    check("rp_valid", 32'(ir_valid), 32'h0);
    check("rp_count", 32'(instr_count), 32'h0);

    // sweep every opcode with every RX/RY
    exp_cnt = 16'h0;
    for (int op = 0; op < 16; op++) begin
      for (int r = 0; r < 16; r++) begin
        word = {4'(op), 4'(r), 8'($urandom_range(255, 0))};
        exp_op = expect_decode(word);
        step(1'b0, 1'b1, 1'b0, word);
        exp_cnt = exp_cnt + 16'h1;
        check("sweep_opcode", 32'(opcode_out), 32'(exp_op));
        check("sweep_onehot", 32'($countones(opcode_out[22:0])), 32'h1);
        check("sweep_imm", 32'(imm_out), 32'(word[7:0]));
      end
    end
    check("sweep_count", 32'(instr_count), 32'(exp_cnt));

    // counter wrap
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 65535; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
    check("cnt_ffff", 32'(instr_count), 32'hFFFF);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    check("cnt_wrap", 32'(instr_count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
